prog_seq: RTL and testbench
===========================

# prog_seq

Program sequencer that drives the jump interface of `ProgCtr` (`Jen`, `Jump`) and reads back its `PC`. It implements the Start/Done handshake with the testbench and selects one of four program entry points. It resolves absolute and flag-conditional branches through a constant target lookup table, and freezes the PC while idle or halted. It sits between the instruction decoder and `ProgCtr` in the fetch stage.

## Interface
- `PC_W`, 10, width of PC and jump target
- `LUT_W`, 4, width of branch-LUT index (16 entries)
- `Clk`  in  1  system clock; all state changes on rising edge
- `Reset`  in  1  synchronous, active-high reset
- `Start`  in  1  testbench start request (level)
- `ProgSel`  in  2  program entry select, sampled on the Start rising edge
- `PC`  in  PC_W  current PC from `ProgCtr`
- `Halt`  in  1  decoded halt instruction
- `BrAbs`  in  1  decoded unconditional branch
- `BrCond`  in  1  decoded branch-if-flag
- `LutIdx`  in  LUT_W  branch target index from the instruction
- `FlagWe`  in  1  load the branch flag from `ALU_flag`
- `ALU_flag`  in  1  ALU compare result
- `Jen`  out  1  to `ProgCtr`: load `Jump` into PC at the next edge
- `Jump`  out  PC_W  absolute next-PC target
- `Busy`  out  1  program running
- `Done`  out  1  program finished, registered

## Operation
- States: IDLE, ARMED, RUN, DONE. Reset places the block in IDLE, clears `flag_q` to 0 and clears `Done` to 0.
- IDLE: `Jen`=1, `Jump`=`PC` (PC held). On `Start`=1, capture `ProgSel` into `sel_q` and go to ARMED.
- ARMED: while `Start`=1, hold the PC (`Jen`=1, `Jump`=`PC`). When `Start`=0, drive `Jen`=1, `Jump`=`PROG_BASE[sel_q]` and go to RUN.
- RUN: `Busy`=1. The default is `Jen`=0, so `ProgCtr` increments. Priority is Halt > BrAbs > BrCond:
  - Halt: `Jen`=1, `Jump`=`PC`; go to DONE.
  - BrAbs: `Jen`=1, `Jump`=`LUT[LutIdx]`.
  - BrCond: `Jen`=`flag_q`, `Jump`=`LUT[LutIdx]`.
- Flag: `FlagWe`=1 loads `flag_q`<=`ALU_flag` in any state. When `FlagWe` and `BrCond` are asserted in the same cycle, the branch uses the old `flag_q`.
- DONE: `Done`=1 and the PC is held. `Start`=1 re-captures `ProgSel` and moves to ARMED. `Done` falls on that same edge.
- `Busy`=1 only in RUN. `Done`=1 only in DONE.
- Width rules:
  - `Jump` is always a full PC_W value; the block does no relative arithmetic.
  - LUT and PROG_BASE entries are PC_W-bit constants.
  - PC wrap from 1023 to 0 is the responsibility of `ProgCtr`; this block does not guard against it.
- Branch inputs are ignored outside RUN.
- Reset mid-program returns the block to IDLE on the next edge with `Done`=0 and `flag_q`=0. `ProgCtr` resets to 0 on the same edge.

## Timing
- `Jen` and `Jump` are combinational from state, `PC`, the decode inputs and `flag_q`. They are valid in the same cycle, and `ProgCtr` consumes them at the next edge.
- The new PC is visible one cycle after a branch, halt or launch decision.
- Start handshake:
  - Start asserted at edge N: the block is in ARMED after N and the PC is unchanged.
  - Start deasserted while in ARMED (first edge M with `Start`=0): the launch target is driven and PC = `PROG_BASE[sel_q]` after M.
  - The first instruction executes in the cycle after M.
- Halt at edge N: the block is in DONE after N, with `Done`=1 and the PC frozen at the halt address.
- A `Start` pulse of one cycle is sufficient. `Start` held high keeps the block in ARMED indefinitely.

## Structure
- `prog_seq_pkg` holds:
  - the state enum `seq_state_t`
  - `PC_W` and `LUT_W` localparams
  - `PROG_BASE[4]` = {0, 100, 200, 300}
  - `BRANCH_LUT[16]`, with entry 2 = 10, entry 5 = 16 and the remaining entries defined by the assembler team
- Sub-module `branch_lut`: a combinational ROM (`LutIdx` -> target), reused by the assembler cross-check bench.
- Top level contains the state register, `sel_q`, `flag_q`, `Done` register and next-PC mux.

## Test plan
- Reset:
  - `Reset`=1 for one edge: state is IDLE, `Done`=0, `Busy`=0, `Jen`=1, `Jump`=`PC`.
  - Release and clock 3 edges with `Start`=0: PC stays 0.
- Launch:
  - `ProgSel`=1, `Start`=1 for two edges: PC held at 0.
  - `Start`=0: after one edge PC = 100 and `Busy`=1. The next edge gives PC = 101.
- Absolute branch: in RUN at PC = 101, `BrAbs`=1 with `LutIdx`=2 → `Jen`=1, `Jump`=10, PC = 10 after the edge.
- Conditional branch:
  - `FlagWe`=1 with `ALU_flag`=0, then `BrCond` with `LutIdx`=5 → `Jen`=0, PC increments.
  - Repeat with the flag loaded as 1 → PC = 16.
  - `FlagWe`=1 with `ALU_flag`=1 together with `BrCond` while `flag_q`=0 → PC increments (old flag used).
- Halt and restart:
  - `Halt`=1 together with `BrAbs`=1 at PC = 20 → `Done`=1, PC stays 20 for 5 edges.
  - `Start` with `ProgSel`=3, then release → `Done`=0, PC = 300.
- Reset mid-run: `Reset`=1 while in RUN at PC = 205 → state IDLE, `flag_q`=0, `Done`=0, PC = 0, and PC stays 0 until the next Start.

Source files
------------

// File: rtl/prog_seq_pkg.sv
// Shared types and constants for the program sequencer: state encoding,
// widths, program entry points and the branch target table.
package prog_seq_pkg;

  localparam int unsigned PC_W  = 10;
  localparam int unsigned LUT_W = 4;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StRun,
    StDone
  } seq_state_t;

  // Program entry points selected by ProgSel at Start.
  function automatic logic [PC_W-1:0] progBase(input logic [1:0] sel);
    logic [PC_W-1:0] base;
    unique case (sel)
      2'd0:    base = 10'd0;
      2'd1:    base = 10'd100;
      2'd2:    base = 10'd200;
      default: base = 10'd300;
    endcase
    return base;
  endfunction

  // Absolute branch targets; entries 2 and 5 are relied on by existing programs.
  function automatic logic [PC_W-1:0] branchLut(input logic [LUT_W-1:0] idx);
    logic [PC_W-1:0] target;
    unique case (idx)
      4'd0:    target = 10'd0;
      4'd1:    target = 10'd4;
      4'd2:    target = 10'd10;
      4'd3:    target = 10'd12;
      4'd4:    target = 10'd14;
      4'd5:    target = 10'd16;
      4'd6:    target = 10'd32;
      4'd7:    target = 10'd48;
      4'd8:    target = 10'd64;
      4'd9:    target = 10'd96;
      4'd10:   target = 10'd128;
      4'd11:   target = 10'd256;
      4'd12:   target = 10'd384;
      4'd13:   target = 10'd512;
      4'd14:   target = 10'd768;
      default: target = 10'd1000;
    endcase
    return target;
  endfunction

endpackage

// File: rtl/prog_seq_branch_lut.sv
// Combinational branch-target ROM, shared with the assembler cross-check bench.
module branch_lut
  import prog_seq_pkg::*;
(
  input  logic [LUT_W-1:0] LutIdx,
  output logic [PC_W-1:0]  Target
);

  always_comb begin
    Target = branchLut(LutIdx);
  end

endmodule

// File: rtl/prog_seq.sv
// Fetch-stage program sequencer: Start/Done handshake, program launch and
// absolute / flag-conditional branch resolution driving ProgCtr's jump port.
module prog_seq
  import prog_seq_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       ProgSel,
  input  logic [PC_W-1:0]  PC,
  input  logic             Halt,
  input  logic             BrAbs,
  input  logic             BrCond,
  input  logic [LUT_W-1:0] LutIdx,
  input  logic             FlagWe,
  input  logic             ALU_flag,
  output logic             Jen,
  output logic [PC_W-1:0]  Jump,
  output logic             Busy,
  output logic             Done
);

  seq_state_t      stateQ, stateD;
  logic [1:0]      selQ;
  logic            flagQ;
  logic [PC_W-1:0] lutTarget;

  branch_lut uLut (
    .LutIdx (LutIdx),
    .Target (lutTarget)
  );

  // Default holds the PC by reloading it; only RUN lets ProgCtr increment.
  always_comb begin
    stateD = stateQ;
    Jen    = 1'b1;
    Jump   = PC;
    unique case (stateQ)
      StIdle: begin
        if (Start) stateD = StArmed;
      end
      StArmed: begin
        if (!Start) begin
          Jump   = progBase(selQ);
          stateD = StRun;
        end
      end
      StRun: begin
        Jen = 1'b0;
        if (Halt) begin
          Jen    = 1'b1;
          Jump   = PC;
          stateD = StDone;
        end else if (BrAbs) begin
          Jen  = 1'b1;
          Jump = lutTarget;
        end else if (BrCond) begin
          Jen  = flagQ;
          Jump = lutTarget;
        end
      end
      StDone: begin
        if (Start) stateD = StArmed;
      end
      default: stateD = StIdle;
    endcase
  end

  // Busy/Done are registered from the next state so they track stateQ exactly.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stateQ <= StIdle;
      selQ   <= 2'd0;
      flagQ  <= 1'b0;
      Busy   <= 1'b0;
      Done   <= 1'b0;
    end else begin
      stateQ <= stateD;
      Busy   <= (stateD == StRun);
      Done   <= (stateD == StDone);
      if (FlagWe) flagQ <= ALU_flag;
      if (Start && (stateQ == StIdle || stateQ == StDone)) selQ <= ProgSel;
    end
  end

endmodule

// File: tb/tb_prog_seq.sv
// Directed bench for prog_seq with a behavioural ProgCtr and a PC scoreboard.
module tb_prog_seq;
  import prog_seq_pkg::*;

  logic             Clk = 1'b0;
  logic             Reset, Start, Halt, BrAbs, BrCond, FlagWe, ALU_flag;
  logic [1:0]       ProgSel;
  logic [LUT_W-1:0] LutIdx;
  logic [PC_W-1:0]  Pc;
  logic             Jen, Busy, Done;
  logic [PC_W-1:0]  Jump;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    string       tag;
    logic [31:0] value;
  } exp_t;
  exp_t pcQueue[$];

  always #5 Clk = ~Clk;

  prog_seq dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .ProgSel  (ProgSel),
    .PC       (Pc),
    .Halt     (Halt),
    .BrAbs    (BrAbs),
    .BrCond   (BrCond),
    .LutIdx   (LutIdx),
    .FlagWe   (FlagWe),
    .ALU_flag (ALU_flag),
    .Jen      (Jen),
    .Jump     (Jump),
    .Busy     (Busy),
    .Done     (Done)
  );

  // ProgCtr stand-in: load on Jen, otherwise increment.
  always_ff @(posedge Clk) begin
    if (Reset)    Pc <= '0;
    else if (Jen) Pc <= Jump;
    else          Pc <= Pc + 10'd1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic expectPc(input string tag, input logic [31:0] value);
    exp_t e;
    e.tag   = tag;
    e.value = value;
    pcQueue.push_back(e);
  endtask

  // One edge, then compare the PC against the oldest scoreboard entry.
  task automatic tick();
    exp_t e;
    @(posedge Clk);
    #1;
    if (pcQueue.size() == 0) begin
      compared++;
      mismatched++;
      $error("FAIL scoreboard_empty observed=%0d expected=entry", Pc);
    end else begin
      e = pcQueue.pop_front();
      check(e.tag, {22'd0, Pc}, e.value);
    end
  endtask

  task automatic stepPc(input string tag, input logic [31:0] value);
    expectPc(tag, value);
    tick();
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; ProgSel = 2'd0; Halt = 1'b0; BrAbs = 1'b0;
    BrCond = 1'b0; LutIdx = '0; FlagWe = 1'b0; ALU_flag = 1'b0;

    stepPc("reset_pc", 0);
    check("reset_done", Done, 0);
    check("reset_busy", Busy, 0);
    check("reset_jen", Jen, 1);
    check("reset_jump", Jump, 0);

    Reset = 1'b0;
    for (int i = 0; i < 3; i++) stepPc("idle_pc", 0);

    // Launch program 1 with Start held two edges.
    ProgSel = 2'd1; Start = 1'b1;
    stepPc("armed_pc0", 0);
    stepPc("armed_pc1", 0);
    check("armed_busy", Busy, 0);
    Start = 1'b0; ProgSel = 2'd0;
    #1;
    check("launch_jen", Jen, 1);
    check("launch_jump", Jump, 100);
    stepPc("launch_pc", 100);
    check("run_busy", Busy, 1);
    stepPc("run_inc", 101);

    // Absolute branch.
    BrAbs = 1'b1; LutIdx = 4'd2;
    #1;
    check("brabs_jen", Jen, 1);
    check("brabs_jump", Jump, 10);
    stepPc("brabs_pc", 10);
    BrAbs = 1'b0;

    // Conditional branch, flag clear then set.
    FlagWe = 1'b1; ALU_flag = 1'b0;
    stepPc("flag0_pc", 11);
    FlagWe = 1'b0; BrCond = 1'b1; LutIdx = 4'd5;
    #1;
    check("brcond0_jen", Jen, 0);
    stepPc("brcond0_pc", 12);
    BrCond = 1'b0; FlagWe = 1'b1; ALU_flag = 1'b1;
    stepPc("flag1_pc", 13);
    FlagWe = 1'b0; BrCond = 1'b1;
    #1;
    check("brcond1_jen", Jen, 1);
    check("brcond1_jump", Jump, 16);
    stepPc("brcond1_pc", 16);

    // Same-cycle flag write must not affect the branch.
    BrCond = 1'b0; FlagWe = 1'b1; ALU_flag = 1'b0;
    stepPc("flag0b_pc", 17);
    FlagWe = 1'b1; ALU_flag = 1'b1; BrCond = 1'b1;
    #1;
    check("oldflag_jen", Jen, 0);
    stepPc("oldflag_pc", 18);
    FlagWe = 1'b0; ALU_flag = 1'b0; BrCond = 1'b0;
    stepPc("run_pc19", 19);
    stepPc("run_pc20", 20);

    // Halt wins over BrAbs; branches ignored while done.
    Halt = 1'b1; BrAbs = 1'b1; LutIdx = 4'd2;
    #1;
    check("halt_jump", Jump, 20);
    stepPc("halt_pc", 20);
    check("halt_done", Done, 1);
    check("halt_busy", Busy, 0);
    Halt = 1'b0;
    for (int i = 0; i < 5; i++) stepPc("done_hold_pc", 20);
    BrAbs = 1'b0;

    // Restart into program 3.
    Start = 1'b1; ProgSel = 2'd3;
    stepPc("restart_armed_pc", 20);
    check("restart_done_fall", Done, 0);
    Start = 1'b0;
    stepPc("restart_pc", 300);
    check("restart_busy", Busy, 1);

    // Halt, launch program 2, load flag, then reset mid-run at 205.
    Halt = 1'b1;
    stepPc("halt2_pc", 300);
    Halt = 1'b0; Start = 1'b1; ProgSel = 2'd2;
    stepPc("armed2_pc", 300);
    Start = 1'b0;
    stepPc("launch2_pc", 200);
    FlagWe = 1'b1; ALU_flag = 1'b1;
    stepPc("run2_pc", 201);
    FlagWe = 1'b0;
    for (int i = 202; i <= 205; i++) stepPc("run2_inc", i);
    Reset = 1'b1;
    stepPc("midreset_pc", 0);
    check("midreset_done", Done, 0);
    check("midreset_busy", Busy, 0);
    Reset = 1'b0;
    BrAbs = 1'b1; LutIdx = 4'd9;
    for (int i = 0; i < 3; i++) stepPc("midreset_idle_pc", 0);
    BrAbs = 1'b0;

    // Flag must have been cleared by reset.
    Start = 1'b1; ProgSel = 2'd0;
    stepPc("armed3_pc", 0);
    Start = 1'b0;
    stepPc("launch3_pc", 0);
    BrCond = 1'b1; LutIdx = 4'd5;
    #1;
    check("flag_cleared_jen", Jen, 0);
    stepPc("flag_cleared_pc", 1);
    BrCond = 1'b0;

    if (pcQueue.size() != 0) begin
      compared++;
      mismatched++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", pcQueue.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
